// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//
// Circular in-order reorder buffer sitting between dispatch / CDB writeback and
// the in-order commit stage. One entry may be allocated per cycle at the tail.
// Results arrive out of order by tag on the writeback bus. At most one
// completed head entry retires per cycle. A retiring entry is presented to
// commit on registered outputs, together with a one-cycle valid strobe. A
// flush discards every in-flight entry and returns both pointers to zero.
//
// Ports:
//   clk, rst_n        rising-edge clock; asynchronous active-low reset
//   alloc_valid       dispatch requests a new entry
//   alloc_ready       buffer not full (derived from registered count only)
//   alloc_dest_reg    architectural destination of the dispatched instruction
//   alloc_instr_type  instruction type code (ITYPE_* encoding, carried opaquely)
//   alloc_tag         tag the allocation receives this cycle (the tail pointer)
//   wb_valid          writeback bus carries a result
//   wb_tag            entry index the result belongs to
//   wb_result         result value
//   flush             discard all in-flight entries (dominates everything)
//   rob_valid         one-cycle strobe: retiring entry presented this cycle
//   rob_result        result of the retiring entry (holds between strobes)
//   rob_dest_reg      destination register of the retiring entry
//   rob_instr_type    instruction type of the retiring entry
//   rob_count         number of occupied entries (0..DEPTH)
// -----------------------------------------------------------------------------
module reorder_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,               // power of two, >= 2
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  // dispatch
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic [4:0]       alloc_dest_reg,
  input  logic [3:0]       alloc_instr_type,
  output logic [TAG_W-1:0] alloc_tag,
  // writeback bus
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic [XLEN-1:0]  wb_result,
  // mispredict recovery
  input  logic             flush,
  // commit
  output logic             rob_valid,
  output logic [XLEN-1:0]  rob_result,
  output logic [4:0]       rob_dest_reg,
  output logic [3:0]       rob_instr_type,
  output logic [TAG_W:0]   rob_count
);

  localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

  // Per-entry control bits (reset) and payload (not reset).
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] done_q;
  logic [4:0]       dest_q   [DEPTH];
  logic [3:0]       type_q   [DEPTH];
  logic [XLEN-1:0]  result_q [DEPTH];

  logic [TAG_W-1:0] head_q;
  logic [TAG_W-1:0] tail_q;
  logic [TAG_W:0]   count_q;

  logic alloc_fire;
  logic wb_fire;
  logic retire_fire;

  // ---------------------------------------------------------------------------
  // Handshake and event qualification. Flush suppresses every other event.
  // ---------------------------------------------------------------------------
  assign alloc_ready = (count_q != FULL_COUNT);
  assign alloc_tag   = tail_q;
  assign rob_count   = count_q;

  assign alloc_fire  = alloc_valid && alloc_ready && !flush;
  // The tail entry is never busy while alloc_ready is high, so a writeback
  // cannot hit the entry being allocated in the same cycle.
  assign wb_fire     = wb_valid && busy_q[wb_tag] && !flush;
  // done_q is registered: a result written this cycle retires next cycle at
  // the earliest, so writeback and retirement of one entry never coincide.
  assign retire_fire = busy_q[head_q] && done_q[head_q] && !flush;

  // ---------------------------------------------------------------------------
  // Control state: busy/done bits, pointers, occupancy.
  // ---------------------------------------------------------------------------
  // NOTE: all sequential state uses non-blocking assignments, so every
  // register samples pre-edge values; where two assignments target the same
  // bit in one edge, the later one in program order takes effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      busy_q  <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (wb_fire) begin
        done_q[wb_tag] <= 1'b1;
      end

      // Placed after the writeback so that freeing the head wins over a late
      // writeback aimed at the same entry.
      if (retire_fire) begin
        busy_q[head_q] <= 1'b0;
        done_q[head_q] <= 1'b0;
        head_q         <= head_q + 1'b1;   // wraps DEPTH-1 -> 0
      end

      if (alloc_fire) begin
        busy_q[tail_q] <= 1'b1;
        done_q[tail_q] <= 1'b0;
        tail_q         <= tail_q + 1'b1;   // wraps DEPTH-1 -> 0
      end

      unique case ({alloc_fire, retire_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;       // idle, or alloc and retire together
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Entry payload.
  // ---------------------------------------------------------------------------
  // NOTE: the payload arrays are deliberately left without reset; busy/done
  // gate every read, so stale contents are never observable, and the arrays
  // stay plain storage without reset fan-out.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      dest_q[tail_q] <= alloc_dest_reg;
      type_q[tail_q] <= alloc_instr_type;
    end
    if (wb_fire) begin
      result_q[wb_tag] <= wb_result;       // a repeated writeback overwrites
    end
  end

  // ---------------------------------------------------------------------------
  // Commit interface: registered strobe plus data that holds between strobes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rob_valid      <= 1'b0;
      rob_result     <= '0;
      rob_dest_reg   <= '0;
      rob_instr_type <= '0;
    end else begin
      rob_valid <= retire_fire;            // retire_fire already excludes flush
      if (retire_fire) begin
        rob_result     <= result_q[head_q];
        rob_dest_reg   <= dest_q[head_q];
        rob_instr_type <= type_q[head_q];
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
//
// Directed bench for reorder_buffer. A queue-based model of the buffer
// predicts every output. A negedge compare process checks the DUT against
// that model every cycle. Hand-computed literal checks pin the model at the
// key points of each scenario.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reorder_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 16;
  localparam int TAG_W = 4;

  localparam logic [3:0] ITYPE_ALU    = 4'h0;
  localparam logic [3:0] ITYPE_LOAD   = 4'h1;
  localparam logic [3:0] ITYPE_BRANCH = 4'h3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             alloc_valid = 1'b0;
  logic             alloc_ready;
  logic [4:0]       alloc_dest_reg = '0;
  logic [3:0]       alloc_instr_type = '0;
  logic [TAG_W-1:0] alloc_tag;
  logic             wb_valid = 1'b0;
  logic [TAG_W-1:0] wb_tag = '0;
  logic [XLEN-1:0]  wb_result = '0;
  logic             flush = 1'b0;
  logic             rob_valid;
  logic [XLEN-1:0]  rob_result;
  logic [4:0]       rob_dest_reg;
  logic [3:0]       rob_instr_type;
  logic [TAG_W:0]   rob_count;

  reorder_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .alloc_valid      (alloc_valid),
    .alloc_ready      (alloc_ready),
    .alloc_dest_reg   (alloc_dest_reg),
    .alloc_instr_type (alloc_instr_type),
    .alloc_tag        (alloc_tag),
    .wb_valid         (wb_valid),
    .wb_tag           (wb_tag),
    .wb_result        (wb_result),
    .flush            (flush),
    .rob_valid        (rob_valid),
    .rob_result       (rob_result),
    .rob_dest_reg     (rob_dest_reg),
    .rob_instr_type   (rob_instr_type),
    .rob_count        (rob_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: program order is a queue of tags; an entry is in flight exactly
  // while its tag is in the queue.
  // ---------------------------------------------------------------------------
  bit              m_busy [DEPTH];
  bit              m_done [DEPTH];
  logic [4:0]      m_dest [DEPTH];
  logic [3:0]      m_type [DEPTH];
  logic [XLEN-1:0] m_res  [DEPTH];
  int unsigned     m_order[$];
  int unsigned     m_tail = 0;
  bit              e_valid = 1'b0;
  logic [XLEN-1:0] e_result = '0;
  logic [4:0]      e_dest = '0;
  logic [3:0]      e_type = '0;

  task automatic model_clear(input bit hard);
    m_order.delete();
    m_tail  = 0;
    e_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      m_busy[i] = 1'b0;
      m_done[i] = 1'b0;
    end
    if (hard) begin
      e_result = '0;
      e_dest   = '0;
      e_type   = '0;
    end
  endtask

  task automatic model_edge();
    bit          can_alloc;
    bit          can_retire;
    int unsigned h;
    can_alloc  = alloc_valid && (m_order.size() < DEPTH);
    can_retire = (m_order.size() != 0) && m_done[m_order[0]];
    e_valid    = can_retire;
    if (can_retire) begin
      h        = m_order.pop_front();
      e_result = m_res[h];
      e_dest   = m_dest[h];
      e_type   = m_type[h];
      m_busy[h] = 1'b0;
      m_done[h] = 1'b0;
    end
    if (wb_valid && m_busy[wb_tag]) begin
      m_done[wb_tag] = 1'b1;
      m_res[wb_tag]  = wb_result;
    end
    if (can_alloc) begin
      m_order.push_back(m_tail);
      m_busy[m_tail] = 1'b1;
      m_done[m_tail] = 1'b0;
      m_dest[m_tail] = alloc_dest_reg;
      m_type[m_tail] = alloc_instr_type;
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     model_clear(1'b1);
    else if (flush) model_clear(1'b0);
    else            model_edge();
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("alloc_ready", alloc_ready, m_order.size() != DEPTH);
    check("alloc_tag", alloc_tag, m_tail);
    check("rob_count", rob_count, m_order.size());
    check("rob_valid", rob_valid, e_valid);
    check("rob_result", rob_result, e_result);
    check("rob_dest_reg", rob_dest_reg, e_dest);
    check("rob_instr_type", rob_instr_type, e_type);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change at negedge, held through the next posedge.
  // ---------------------------------------------------------------------------
  task automatic cyc(input bit av, input logic [4:0] d, input logic [3:0] t,
                     input bit wv, input logic [TAG_W-1:0] wt,
                     input logic [XLEN-1:0] wr, input bit fl);
    alloc_valid      = av;
    alloc_dest_reg   = d;
    alloc_instr_type = t;
    wb_valid         = wv;
    wb_tag           = wt;
    wb_result        = wr;
    flush            = fl;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 4'd0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic alloc(input logic [4:0] d, input logic [3:0] t);
    cyc(1'b1, d, t, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic wb(input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] r);
    cyc(1'b0, 5'd0, 4'd0, 1'b1, tag, r, 1'b0);
  endtask

  task automatic do_flush();
    cyc(1'b0, 5'd0, 4'd0, 1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---- reset then idle ----
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("post_reset_count", rob_count, 0);
    check("post_reset_ready", alloc_ready, 1);
    repeat (3) idle();
    check("idle_no_valid", rob_valid, 0);

    // ---- out-of-order completion ----
    check("ooo_tag0", alloc_tag, 0);
    alloc(5'd1, ITYPE_ALU);
    check("ooo_tag1", alloc_tag, 1);
    alloc(5'd2, ITYPE_ALU);
    check("ooo_tag2", alloc_tag, 2);
    alloc(5'd3, ITYPE_ALU);
    check("ooo_count3", rob_count, 3);
    wb(4'd2, 32'h33);
    wb(4'd0, 32'h11);
    check("ooo_not_yet", rob_valid, 0);
    wb(4'd1, 32'h22);
    check("ooo_r0_valid", rob_valid, 1);
    check("ooo_r0_result", rob_result, 32'h11);
    check("ooo_r0_dest", rob_dest_reg, 1);
    idle();
    check("ooo_r1_valid", rob_valid, 1);
    check("ooo_r1_result", rob_result, 32'h22);
    check("ooo_r1_dest", rob_dest_reg, 2);
    idle();
    check("ooo_r2_valid", rob_valid, 1);
    check("ooo_r2_result", rob_result, 32'h33);
    check("ooo_r2_dest", rob_dest_reg, 3);
    idle();
    check("ooo_done_valid", rob_valid, 0);
    check("ooo_empty", rob_count, 0);

    // ---- asynchronous reset mid-operation ----
    alloc(5'd4, ITYPE_LOAD);
    alloc(5'd5, ITYPE_LOAD);
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", rob_valid, 0);
    check("rst_result", rob_result, 0);
    check("rst_dest", rob_dest_reg, 0);
    check("rst_type", rob_instr_type, 0);
    check("rst_count", rob_count, 0);
    check("rst_ready", alloc_ready, 1);
    check("rst_tag", alloc_tag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle();
    check("rst_idle_valid", rob_valid, 0);

    // ---- flush with same-cycle writeback and alloc ----
    for (int i = 0; i < 4; i++) alloc(5'(10 + i), (i == 3) ? ITYPE_BRANCH : ITYPE_ALU);
    wb(4'd0, 32'hA0);                       // head done: would retire on flush edge
    check("fl_count4", rob_count, 4);
    cyc(1'b1, 5'd20, ITYPE_ALU, 1'b1, 4'd1, 32'hA1, 1'b1);
    check("fl_count0", rob_count, 0);
    check("fl_tag0", alloc_tag, 0);
    check("fl_no_valid", rob_valid, 0);
    idle();
    check("fl_no_valid2", rob_valid, 0);
    wb(4'd2, 32'hA2);
    idle();
    check("fl_stale_wb_valid", rob_valid, 0);
    check("fl_stale_wb_count", rob_count, 0);

    // ---- writeback to an unallocated tag ----
    alloc(5'd1, ITYPE_ALU);
    alloc(5'd2, ITYPE_LOAD);
    wb(4'd7, 32'h77);
    idle();
    check("ua_count2", rob_count, 2);
    check("ua_no_valid", rob_valid, 0);
    for (int i = 2; i < 8; i++) alloc(5'(i), ITYPE_ALU);
    for (int t = 0; t < 7; t++) wb(4'(t), 32'h100 + t);
    repeat (8) idle();
    check("ua_tag7_waits_count", rob_count, 1);
    check("ua_tag7_waits_valid", rob_valid, 0);
    wb(4'd7, 32'h7777);
    idle();
    check("ua_tag7_valid", rob_valid, 1);
    check("ua_tag7_result", rob_result, 32'h7777);
    check("ua_tag7_dest", rob_dest_reg, 7);

    // ---- simultaneous alloc and retire at count 5 (head = tail = 8) ----
    for (int i = 0; i < 5; i++) alloc(5'(8 + i), ITYPE_ALU);
    wb(4'd8, 32'h808);
    check("sim_count5", rob_count, 5);
    check("sim_tag13", alloc_tag, 13);
    alloc(5'd30, ITYPE_LOAD);
    check("sim_count_hold", rob_count, 5);
    check("sim_valid", rob_valid, 1);
    check("sim_result", rob_result, 32'h808);
    check("sim_tail_adv", alloc_tag, 14);
    wb(4'd9, 32'h909);
    idle();
    check("sim_head_adv_valid", rob_valid, 1);
    check("sim_head_adv_result", rob_result, 32'h909);
    do_flush();
    idle();

    // ---- full and wrap ----
    for (int i = 0; i < 16; i++) alloc(5'(i), ITYPE_ALU);
    check("full_ready", alloc_ready, 0);
    check("full_count", rob_count, 16);
    check("full_tag", alloc_tag, 0);
    alloc(5'd31, ITYPE_LOAD);               // ignored while full
    check("full_ignored_count", rob_count, 16);
    wb(4'd0, 32'hF0);
    check("full_still_not_ready", alloc_ready, 0);
    idle();
    check("wrap_retire_valid", rob_valid, 1);
    check("wrap_retire_result", rob_result, 32'hF0);
    check("wrap_ready", alloc_ready, 1);
    check("wrap_count15", rob_count, 15);
    check("wrap_tag0", alloc_tag, 0);
    alloc(5'd25, ITYPE_ALU);
    check("wrap_refill_count", rob_count, 16);
    check("wrap_refill_ready", alloc_ready, 0);
    do_flush();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer between dispatch/CDB writeback and the in-order commit stage.
- Allocates one entry per cycle at dispatch and captures out-of-order results by tag from the writeback bus.
- Retires at most one completed head entry per cycle, presenting registered result/dest/type with a one-cycle valid strobe to commit.
- Supports a full pipeline flush on branch mispredict.

Parameters:
- XLEN, 32, data width of results.
- DEPTH, 16, number of entries; must be a power of 2 and at least 2.
- TAG_W, $clog2(DEPTH), width of entry index/tag.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- alloc_valid  input  1  dispatch requests a new entry.
- alloc_ready  output  1  buffer can accept an allocation this cycle.
- alloc_dest_reg  input  5  architectural destination register of the dispatched instruction.
- alloc_instr_type  input  4  instruction type code, using the codebase ITYPE_* encodings.
- alloc_tag  output  TAG_W  index of the entry allocated this cycle; equals the tail pointer.
- wb_valid  input  1  writeback bus carries a result.
- wb_tag  input  TAG_W  entry index the result belongs to.
- wb_result  input  XLEN  result value.
- flush  input  1  discard all in-flight entries.
- rob_valid  output  1  one-cycle strobe: the retiring entry is presented this cycle.
- rob_result  output  XLEN  result of the retiring entry.
- rob_dest_reg  output  5  destination register of the retiring entry.
- rob_instr_type  output  4  instruction type of the retiring entry.
- rob_count  output  TAG_W+1  number of occupied entries.

Behaviour:
- Entry state: busy, done, dest[4:0], type[3:0], result[XLEN-1:0]. Pointers: head and tail (TAG_W bits, wrap modulo DEPTH). Occupancy count: TAG_W+1 bits.
- Reset (async, rst_n=0):
  - All busy/done bits cleared; head = tail = count = 0.
  - rob_valid=0, rob_result=0, rob_dest_reg=0, rob_instr_type=0.
  - Asserting reset mid-operation discards everything immediately.
- alloc_ready = (count != DEPTH). It is derived from registered state only; a retirement in the same cycle does not raise it.
- alloc_tag = tail, presented combinationally.
- Allocation: on a clock edge with alloc_valid && alloc_ready && !flush, the entry at tail gets busy=1, done=0, dest and type written, and tail increments with wrap DEPTH-1 -> 0.
- alloc_valid while full is ignored, with no state change. Dispatch must hold the request until alloc_ready is high.
- Writeback: on a clock edge with wb_valid && !flush, if entry[wb_tag].busy, then done=1 and result=wb_result.
  - Writeback to a non-busy entry is ignored.
  - Writeback to an entry that is already done overwrites its result.
- Retirement: each cycle, if entry[head].busy && entry[head].done && !flush:
  - At the next edge: rob_valid<=1, rob_result/rob_dest_reg/rob_instr_type <= the entry's fields.
  - The entry's busy and done bits are cleared and head increments with wrap.
  - Otherwise rob_valid<=0, and the data outputs hold their last values.
- Latency:
  - Writeback presented in cycle c to the head entry gives rob_valid high in cycle c+2.
  - Allocation in cycle a with writeback in cycle a+1 gives earliest rob_valid in cycle a+3.
  - Throughput is one retirement per cycle.
- The done bit is registered, so writeback and retirement of the same entry in the same cycle cannot occur.
- Count: next = count + (alloc fires) - (retire fires). Simultaneous alloc and retire leaves count unchanged. Empty: head == tail and count == 0. Full: count == DEPTH.
- Flush (sampled at clock edge):
  - Clears all busy/done bits; head = tail = count = 0; rob_valid<=0.
  - Any alloc, writeback or retirement in the same cycle is suppressed. Flush dominates all.
  - Data outputs hold their last values.
- Retirement is unconditional on type. The commit stage decides whether an entry writes the register file; branches and stores also require a writeback to mark them done.

Test Plan:
- Reset then idle: rst_n low mid-simulation -> all outputs 0, alloc_ready=1, rob_count=0. Release reset and apply no stimulus -> rob_valid stays 0.
- Out-of-order completion: alloc tags 0,1,2 (dest x1,x2,x3; ITYPE_ALU). Writeback tag2=0x33, then tag0=0x11, then tag1=0x22 in consecutive cycles -> retires in order x1=0x11, x2=0x22, x3=0x33. Retirements are strobed on consecutive cycles starting 2 cycles after the tag0 writeback.
- Full and wrap: fill 16 entries -> alloc_ready=0, rob_count=16, and a 17th alloc_valid is ignored. Complete and retire entry 0 -> alloc_ready=1 next cycle. The next allocation gets alloc_tag=0 (wrap).
- Simultaneous alloc and retire at count=5 -> rob_count stays 5, and tail and head each advance by 1.
- Flush with 4 entries in flight and a same-cycle writeback and alloc -> next cycle rob_count=0, alloc_tag=0, and no rob_valid strobe follows. A later writeback to old tag 2 is ignored.
- Writeback to an unallocated tag 7 while only tags 0-1 are busy -> no state change. After tag 7 is later allocated, it must not retire until its own writeback arrives.
